// File: rtl/bank_conflict_sched.sv
// Read-priority scheduler for two interleaved single-port banks (bank = address bit 0).
// Writes that lose their bank to a same-cycle read wait in an in-order buffer that also forwards to reads.
module bank_conflict_sched #(
   parameter int AW    = 8,
   parameter int DW    = 16,
   parameter int DEPTH = 2
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       RE,
   input  logic [AW-1:0]              R_ADR,
   input  logic                       WE,
   input  logic [AW-1:0]              W_ADR,
   input  logic [DW-1:0]              W_DATA,
   output logic                       W_READY,
   output logic                       R_VLD,
   output logic [DW-1:0]              R_DATA,
   output logic [$clog2(DEPTH):0]     PEND_CNT,
   output logic                       OVF,
   output logic                       EN_0,
   output logic                       WE_0,
   output logic [AW-2:0]              A_0,
   output logic [DW-1:0]              D_0,
   input  logic [DW-1:0]              Q_0,
   output logic                       EN_1,
   output logic                       WE_1,
   output logic [AW-2:0]              A_1,
   output logic [DW-1:0]              D_1,
   input  logic [DW-1:0]              Q_1
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] buf_adr_q [DEPTH];
   logic [DW-1:0] buf_dat_q [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          rvld_q, rbank_q;
   logic          fhit_q, fhit_d;
   logic [DW-1:0] fdat_q, fdat_d;

   logic          w_acc, have_pend, cand_vld, cand_issue, push, pop;
   logic [AW-1:0] cand_adr;
   logic [DW-1:0] cand_dat;
   logic          rd_b0, rd_b1, wr_b0, wr_b1;

   assign W_READY   = (cnt_q < CW'(DEPTH));
   assign w_acc     = WE & W_READY;
   assign have_pend = (cnt_q != '0);

   // The buffer head always goes first so writes retire in acceptance order.
   assign cand_vld   = have_pend | w_acc;
   assign cand_adr   = have_pend ? buf_adr_q[head_q] : W_ADR;
   assign cand_dat   = have_pend ? buf_dat_q[head_q] : W_DATA;
   assign cand_issue = cand_vld & ~(RE & (R_ADR[0] == cand_adr[0]));
   assign pop        = have_pend & cand_issue;
   assign push       = w_acc & (have_pend | ~cand_issue);

   assign rd_b0 = RE & ~R_ADR[0];
   assign rd_b1 = RE &  R_ADR[0];
   assign wr_b0 = cand_issue & ~cand_adr[0];
   assign wr_b1 = cand_issue &  cand_adr[0];

   assign EN_0 = ~RST & (rd_b0 | wr_b0);
   assign WE_0 = ~RST & wr_b0;
   assign A_0  = ~EN_0 ? '0 : (rd_b0 ? R_ADR[AW-1:1] : cand_adr[AW-1:1]);
   assign D_0  = WE_0 ? cand_dat : '0;
   assign EN_1 = ~RST & (rd_b1 | wr_b1);
   assign WE_1 = ~RST & wr_b1;
   assign A_1  = ~EN_1 ? '0 : (rd_b1 ? R_ADR[AW-1:1] : cand_adr[AW-1:1]);
   assign D_1  = WE_1 ? cand_dat : '0;

   // Newest matching entry wins; the same-cycle incoming write is deliberately not considered.
   always_comb begin
      fhit_d = 1'b0;
      fdat_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (RE && (CW'(k) < cnt_q) && (buf_adr_q[head_q + PW'(k)] == R_ADR)) begin
            fhit_d = 1'b1;
            fdat_d = buf_dat_q[head_q + PW'(k)];
         end
      end
   end

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q | (WE & ~W_READY);
      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         rvld_q  <= 1'b0;
         rbank_q <= 1'b0;
         fhit_q  <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         rvld_q  <= RE;
         rbank_q <= R_ADR[0];
         fhit_q  <= fhit_d;
      end
   end

   always_ff @(posedge CLK) begin
      fdat_q <= fdat_d;
      if (push) begin
         buf_adr_q[tail_q] <= W_ADR;
         buf_dat_q[tail_q] <= W_DATA;
      end
   end

   assign R_VLD    = rvld_q;
   assign R_DATA   = !rvld_q ? '0 : (fhit_q ? fdat_q : (rbank_q ? Q_1 : Q_0));
   assign PEND_CNT = cnt_q;
   assign OVF      = ovf_q;

endmodule

// File: tb/tb_bank_conflict_sched.sv
// Directed bench for bank_conflict_sched: bank reads return fixed per-bank patterns.
module tb_bank_conflict_sched;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int DEPTH = 2;

   logic          CLK = 1'b0;
   logic          RST;
   logic          RE, WE;
   logic [AW-1:0] R_ADR, W_ADR;
   logic [DW-1:0] W_DATA;
   logic          W_READY, R_VLD, OVF;
   logic [DW-1:0] R_DATA;
   logic [1:0]    PEND_CNT;
   logic          EN_0, WE_0, EN_1, WE_1;
   logic [AW-2:0] A_0, A_1;
   logic [DW-1:0] D_0, D_1, Q_0, Q_1;

   int nerr = 0;
   int nchk = 0;

   bank_conflict_sched #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .RE(RE), .R_ADR(R_ADR), .WE(WE), .W_ADR(W_ADR),
      .W_DATA(W_DATA), .W_READY(W_READY), .R_VLD(R_VLD), .R_DATA(R_DATA),
      .PEND_CNT(PEND_CNT), .OVF(OVF),
      .EN_0(EN_0), .WE_0(WE_0), .A_0(A_0), .D_0(D_0), .Q_0(Q_0),
      .EN_1(EN_1), .WE_1(WE_1), .A_1(A_1), .D_1(D_1), .Q_1(Q_1)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic re, input logic [AW-1:0] ra,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      RE = re; R_ADR = ra; WE = we; W_ADR = wa; W_DATA = wd;
      #1;
   endtask

   initial begin
      Q_0 = 16'hC0C0;
      Q_1 = 16'hC1C1;
      RST = 1'b1;
      drive(1'b1, 8'h10, 1'b1, 8'h13, 16'h1234);
      #10;
      chk("rst_en0", EN_0, 0);
      chk("rst_en1", EN_1, 0);
      chk("rst_we1", WE_1, 0);
      chk("rst_wready", W_READY, 1);
      chk("rst_pend", PEND_CNT, 0);
      chk("rst_ovf", OVF, 0);
      chk("rst_rvld", R_VLD, 0);
      chk("rst_rdata", R_DATA, 0);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
      RST = 1'b0;
      tick();

      // conflicting write on bank 0 gets buffered
      drive(1'b1, 8'h10, 1'b1, 8'h12, 16'hAAAA);
      chk("t1_en0", EN_0, 1);
      chk("t1_we0", WE_0, 0);
      chk("t1_a0", A_0, 8'h08);
      chk("t1_en1", EN_1, 0);
      tick();
      chk("t1_pend", PEND_CNT, 1);
      chk("t1_rvld", R_VLD, 1);
      chk("t1_rdata", R_DATA, 16'hC0C0);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
      chk("t1_ret_we0", WE_0, 1);
      chk("t1_ret_a0", A_0, 8'h09);
      chk("t1_ret_d0", D_0, 16'hAAAA);
      tick();
      chk("t1_pend0", PEND_CNT, 0);
      chk("t1_rvld0", R_VLD, 0);
      chk("t1_rdata0", R_DATA, 0);

      // no conflict: read bank 0 and write bank 1 together
      drive(1'b1, 8'h10, 1'b1, 8'h13, 16'h5555);
      chk("t2_a0", A_0, 8'h08);
      chk("t2_we0", WE_0, 0);
      chk("t2_en1", EN_1, 1);
      chk("t2_we1", WE_1, 1);
      chk("t2_a1", A_1, 8'h09);
      chk("t2_d1", D_1, 16'h5555);
      tick();
      chk("t2_pend", PEND_CNT, 0);
      chk("t2_rvld", R_VLD, 1);
      chk("t2_rdata", R_DATA, 16'hC0C0);
      drive(1'b1, 8'h11, 1'b0, 8'h00, 16'h0000);
      tick();
      chk("t2_rdata_b1", R_DATA, 16'hC1C1);

      // fill buffer, overflow, then drain in order
      drive(1'b1, 8'h10, 1'b1, 8'h20, 16'h0001);
      tick();
      drive(1'b1, 8'h10, 1'b1, 8'h22, 16'h0002);
      tick();
      chk("t3_pend2", PEND_CNT, 2);
      chk("t3_wready", W_READY, 0);
      drive(1'b1, 8'h10, 1'b1, 8'h24, 16'h0003);
      chk("t3_blk_we0", WE_0, 0);
      tick();
      chk("t3_ovf", OVF, 1);
      chk("t3_pend_keep", PEND_CNT, 2);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
      chk("t3_r1_a0", A_0, 8'h10);
      chk("t3_r1_d0", D_0, 16'h0001);
      tick();
      chk("t3_pend1", PEND_CNT, 1);
      chk("t3_wready1", W_READY, 1);
      chk("t3_r2_we0", WE_0, 1);
      chk("t3_r2_a0", A_0, 8'h11);
      chk("t3_r2_d0", D_0, 16'h0002);
      tick();
      chk("t3_pend0", PEND_CNT, 0);
      chk("t3_ovf_sticky", OVF, 1);
      chk("t3_idle_en0", EN_0, 0);

      // forwarding from the buffer
      drive(1'b1, 8'h10, 1'b1, 8'h12, 16'hBEEF);
      tick();
      drive(1'b1, 8'h12, 1'b0, 8'h00, 16'h0000);
      chk("t4_blk_we0", WE_0, 0);
      tick();
      chk("t4_rvld", R_VLD, 1);
      chk("t4_fwd", R_DATA, 16'hBEEF);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
      chk("t4_ret_a0", A_0, 8'h09);
      chk("t4_ret_d0", D_0, 16'hBEEF);
      tick();
      chk("t4_pend0", PEND_CNT, 0);

      // head retires while a new write queues behind it
      drive(1'b1, 8'h10, 1'b1, 8'h12, 16'h1111);
      tick();
      drive(1'b0, 8'h00, 1'b1, 8'h15, 16'h2222);
      chk("t5_we0", WE_0, 1);
      chk("t5_a0", A_0, 8'h09);
      chk("t5_d0", D_0, 16'h1111);
      chk("t5_en1", EN_1, 0);
      tick();
      chk("t5_pend1", PEND_CNT, 1);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
      chk("t5_we1", WE_1, 1);
      chk("t5_a1", A_1, 8'h0A);
      chk("t5_d1", D_1, 16'h2222);
      tick();
      chk("t5_pend0", PEND_CNT, 0);

      // read-before-write on the same address
      drive(1'b1, 8'h30, 1'b1, 8'h30, 16'h7777);
      tick();
      chk("t7_rbw", R_DATA, 16'hC0C0);
      chk("t7_pend", PEND_CNT, 1);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
      chk("t7_ret_d0", D_0, 16'h7777);
      tick();

      // asynchronous reset with a full buffer
      drive(1'b1, 8'h10, 1'b1, 8'h20, 16'h00A1);
      tick();
      drive(1'b1, 8'h10, 1'b1, 8'h22, 16'h00A2);
      tick();
      chk("t6_pend2", PEND_CNT, 2);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000);
      chk("t6_pre_we0", WE_0, 1);
      #2 RST = 1'b1;
      #1;
      chk("t6_en0", EN_0, 0);
      chk("t6_we0", WE_0, 0);
      chk("t6_pend", PEND_CNT, 0);
      chk("t6_wready", W_READY, 1);
      #2 RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_post_en0", EN_0, 0);
         chk("t6_post_en1", EN_1, 0);
         chk("t6_post_pend", PEND_CNT, 0);
      end
      chk("t6_ovf_clr", OVF, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/bank_conflict_sched.md
Name: bank_conflict_sched

Overview:
- Scheduler for a two-bank, single-port-RAM pair interleaved on the address LSB (bit 0 = bank select, A[AW-1:1] = bank address).
- Each cycle it accepts one read and one write request and issues them to the banks. Reads always win a bank.
- A write that collides with a same-cycle read on the same bank is deferred into a small in-order pending-write buffer and retired on a later free cycle.
- Reads that hit a buffered address are forwarded from the buffer, so the requester sees a coherent memory.

Parameters:
AW, 8, request address width (bank address = AW-1 bits)
DW, 16, data width
DEPTH, 2, pending-write buffer entries (power of 2, >=2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
RE  in  1  read request
R_ADR  in  AW  read address
WE  in  1  write request, accepted only when W_READY=1
W_ADR  in  AW  write address
W_DATA  in  DW  write data
W_READY  out  1  buffer not full
R_VLD  out  1  read data valid, one cycle after RE
R_DATA  out  DW  read data
PEND_CNT  out  clog2(DEPTH)+1  buffered write count
OVF  out  1  sticky: WE seen while W_READY=0
EN_0, WE_0  out  1 each  bank 0 enable / write strobe
A_0  out  AW-1  bank 0 address
D_0  out  DW  bank 0 write data
Q_0  in  DW  bank 0 read data (synchronous, valid cycle after EN_0 & ~WE_0)
EN_1, WE_1, A_1, D_1, Q_1  same for bank 1

Behaviour:
- Reset: buffer flushed, PEND_CNT=0, OVF=0, R_VLD=0, R_DATA=0, W_READY=1; EN_x/WE_x forced 0 while RST high. Buffered writes are discarded on reset mid-operation and never issued.
- Read path:
  - RE=1: EN_b=1, WE_b=0, A_b=R_ADR[AW-1:1] on b=R_ADR[0], same cycle (combinational).
  - Next cycle R_VLD=1. R_DATA = forwarded data if the read hit the buffer, else Q_b of the registered bank bit.
  - R_DATA=0 when R_VLD=0.
- Write candidate each cycle: buffer head if PEND_CNT>0, else the incoming accepted write.
  - Candidate issues (EN_c=WE_c=1, A_c, D_c) iff its bank c is not read this cycle.
  - Issued head is popped.
- Incoming accepted write (WE & W_READY) is enqueued if PEND_CNT>0 or if it is itself the candidate and blocked. Otherwise it issues directly.
- Ordering: writes retire strictly in acceptance order. At most one write issues per cycle, even if the other bank is idle.
- Simultaneous pop+push keeps PEND_CNT unchanged. W_READY = (PEND_CNT<DEPTH), from registered state.
- Overflow: WE with W_READY=0 is dropped and OVF set; OVF clears only on reset.
- Forwarding: at RE, compare R_ADR against all valid buffer entries and register the newest match's data.
  - An incoming write in the same cycle as a read to the same address is not forwarded: read returns pre-write data (read-before-write).
- Unused bank outputs: A_x=0, D_x=0 when EN_x=0.
- Pointers wrap modulo DEPTH.

Test Plan:
- AW=8,DW=16,DEPTH=2. RE,R_ADR=0x10 with WE,W_ADR=0x12,W_DATA=0xAAAA -> EN_0=1,WE_0=0,A_0=0x08; PEND_CNT=1. Next idle cycle: WE_0=1,A_0=0x09,D_0=0xAAAA; PEND_CNT=0.
- RE,R_ADR=0x10 with WE,W_ADR=0x13,W_DATA=0x5555 -> EN_0 read A_0=0x08 and EN_1,WE_1=1,A_1=0x09,D_1=0x5555 same cycle; PEND_CNT stays 0. Next cycle R_VLD=1, R_DATA=Q_0.
- Reads on bank 0 every cycle while writing 0x20, 0x22 -> PEND_CNT=2, W_READY=0. Third write to 0x24 dropped and OVF=1. When reads stop, 0x20 then 0x22 retire on consecutive cycles.
- Buffered write 0x12=0xBEEF blocked, then next cycle RE,R_ADR=0x12 -> following cycle R_VLD=1, R_DATA=0xBEEF, regardless of Q_0.
- Buffered 0x12=0x1111, then WE,W_ADR=0x15 with no read -> 0x12 issues on bank 0 this cycle, 0x15 enqueued and issues on bank 1 next cycle.
- PEND_CNT=2, assert RST asynchronously mid-cycle -> EN/WE drop immediately, PEND_CNT=0, W_READY=1. No buffered write issues after release.
